// File: rtl/branch_unit_if.sv
// Bus between the EX/MEM branch unit and its neighbours: branch request, ALU flags,
// fetch-stage redirect and statistics.
interface branch_unit_if #(
   parameter int ADDR_W = 32,
   parameter int OFF_W  = 16
);
   logic              stall;
   logic              flag_we;
   logic [3:0]        flags_in;
   logic              br_valid;
   logic [3:0]        cond;
   logic              target_sel;
   logic [ADDR_W-1:0] pc_in;
   logic [OFF_W-1:0]  offset;
   logic [ADDR_W-1:0] reg_target;
   logic              pc_source;
   logic [ADDR_W-1:0] pc_target;
   logic              flush;
   logic [3:0]        flags_out;
   logic [31:0]       br_count;
   logic [31:0]       taken_count;

   modport master (
      output stall, flag_we, flags_in, br_valid, cond, target_sel, pc_in, offset, reg_target,
      input  pc_source, pc_target, flush, flags_out, br_count, taken_count
   );

   modport slave (
      input  stall, flag_we, flags_in, br_valid, cond, target_sel, pc_in, offset, reg_target,
      output pc_source, pc_target, flush, flags_out, br_count, taken_count
   );
endinterface

// File: rtl/branch_unit.sv
// Branch resolution unit: NZCV flag register with same-cycle bypass, target generation
// and taken-branch flush sequencing. Define BRANCH_UNIT_STATS_EN to build the counters.
module branch_unit #(
   parameter int ADDR_W       = 32,
   parameter int OFF_W        = 16,
   parameter int FLUSH_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   branch_unit_if.slave  bus
);

   localparam int CNT_W = (FLUSH_STAGES > 1) ? $clog2(FLUSH_STAGES) : 1;

   typedef enum logic { IDLE, FLUSH } stateT;

   stateT             stateQ, stateD;
   logic [CNT_W-1:0]  cntQ, cntD;
   logic              pcSourceQ, pcSourceD;
   logic [ADDR_W-1:0] pcTargetQ, pcTargetD;
   logic [3:0]        flagsQ, flagsD;

   logic [3:0]        effFlags;
   logic              condTrue;
   logic              accept;
   logic              takeBr;
   logic [ADDR_W-1:0] offsetExt;
   logic [ADDR_W-1:0] branchTarget;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stateQ    <= IDLE;
         cntQ      <= '0;
         pcSourceQ <= 1'b0;
         pcTargetQ <= '0;
         flagsQ    <= 4'b0000;
      end else begin
         stateQ    <= stateD;
         cntQ      <= cntD;
         pcSourceQ <= pcSourceD;
         pcTargetQ <= pcTargetD;
         flagsQ    <= flagsD;
      end
   end

   // Flags are {N,Z,C,V}; a flag write in the same cycle as the branch is forwarded.
   always_comb begin
      effFlags  = (bus.flag_we && bus.br_valid) ? bus.flags_in : flagsQ;
      condTrue  = 1'b0;
      unique case (bus.cond)
         4'd0:    condTrue = 1'b1;
         4'd1:    condTrue = effFlags[2];
         4'd2:    condTrue = !effFlags[2];
         4'd3:    condTrue = effFlags[3] ^ effFlags[0];
         4'd4:    condTrue = !(effFlags[3] ^ effFlags[0]);
         4'd5:    condTrue = effFlags[2] | (effFlags[3] ^ effFlags[0]);
         4'd6:    condTrue = !effFlags[2] && !(effFlags[3] ^ effFlags[0]);
         4'd7:    condTrue = !effFlags[1];
         4'd8:    condTrue = effFlags[1];
         4'd9:    condTrue = effFlags[3];
         4'd10:   condTrue = !effFlags[3];
         default: condTrue = 1'b0;
      endcase

      offsetExt    = ADDR_W'($signed(bus.offset));
      branchTarget = bus.target_sel ? bus.reg_target : (bus.pc_in + offsetExt);
      accept       = bus.br_valid && !bus.stall && (stateQ == IDLE);
      takeBr       = accept && condTrue;
   end

   // pc_source is a one-cycle pulse unless a stall freezes it in place.
   always_comb begin
      stateD    = stateQ;
      cntD      = cntQ;
      pcSourceD = pcSourceQ;
      pcTargetD = pcTargetQ;
      flagsD    = flagsQ;
      if (!bus.stall) begin
         pcSourceD = 1'b0;
         if (bus.flag_we) flagsD = bus.flags_in;
         unique case (stateQ)
            IDLE: begin
               if (takeBr) begin
                  stateD    = FLUSH;
                  cntD      = CNT_W'(FLUSH_STAGES - 1);
                  pcSourceD = 1'b1;
                  pcTargetD = branchTarget;
               end
            end
            FLUSH: begin
               if (cntQ == '0) stateD = IDLE;
               else            cntD   = cntQ - 1'b1;
            end
            default: stateD = IDLE;
         endcase
      end
   end

   assign bus.pc_source = pcSourceQ;
   assign bus.pc_target = pcTargetQ;
   assign bus.flush     = (stateQ == FLUSH);
   assign bus.flags_out = flagsQ;

`ifdef BRANCH_UNIT_STATS_EN
   logic [31:0] brCountQ, takenCountQ;

   // Saturating counters of accepted and taken branches.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         brCountQ    <= '0;
         takenCountQ <= '0;
      end else begin
         if (accept && (brCountQ != 32'hFFFF_FFFF))    brCountQ    <= brCountQ + 32'd1;
         if (takeBr && (takenCountQ != 32'hFFFF_FFFF)) takenCountQ <= takenCountQ + 32'd1;
      end
   end

   assign bus.br_count    = brCountQ;
   assign bus.taken_count = takenCountQ;
`else
   assign bus.br_count    = 32'd0;
   assign bus.taken_count = 32'd0;
`endif

endmodule
